riscv_trap_ctrl: RTL and testbench

- Machine-mode trap and CSR sequencer for the 5-stage pipeline, sitting beside EX.
- Consumes decoder flags (IllegalInst, ECALL, IsMRET, CSR read/write), holds the M-mode trap CSRs, and arbitrates exceptions against external interrupts.
- Runs a flush/redirect sequence that steers the PC to the trap vector or back to mepc.
- Generalises the decoder's IllegalInst/IsMRET path: parametrised XLEN, interrupt count and flush depth, with vectored mode.

---
 rtl/riscv_trap_ctrl_pkg.sv | 35 +++
 rtl/riscv_trap_ctrl_if.sv | 34 +++
 rtl/riscv_trap_ctrl_irq_prio.sv | 20 ++
 rtl/riscv_trap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_riscv_trap_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// cause codes, CSR operation encodings, FSM states and mstatus bit positions.
package riscv_trap_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Exception cause codes; interrupt i reports IRQ_BASE+i with the MSB set
    localparam int CAUSE_ILLEGAL = 2;
    localparam int CAUSE_ECALL_M = 11;
    localparam int IRQ_BASE      = 16;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_e;

endpackage

// File: rtl/riscv_trap_ctrl_if.sv
// Bundle of EX-stage decoder/CSR inputs and pipeline control outputs
// exchanged between the pipeline (master) and the trap sequencer (slave).
interface riscv_trap_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    logic                ex_valid;
    logic [XLEN-1:0]     ex_pc;
    logic                ex_illegal;
    logic                ex_ecall;
    logic                ex_mret;
    logic [1:0]          csr_op;
    logic [11:0]         csr_addr;
    logic [XLEN-1:0]     csr_wdata;
    logic [XLEN-1:0]     csr_rdata;
    logic [NUM_IRQ-1:0]  irq_i;
    logic                flush;
    logic                stall;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic                trap_active;

    modport master (
        output ex_valid, ex_pc, ex_illegal, ex_ecall, ex_mret,
        output csr_op, csr_addr, csr_wdata, irq_i,
        input  csr_rdata, flush, stall, redirect, redirect_pc, trap_active
    );

    modport slave (
        input  ex_valid, ex_pc, ex_illegal, ex_ecall, ex_mret,
        input  csr_op, csr_addr, csr_wdata, irq_i,
        output csr_rdata, flush, stall, redirect, redirect_pc, trap_active
    );
endinterface

// File: rtl/riscv_trap_ctrl_irq_prio.sv
// Lowest-index-wins priority encoder over the enabled-and-pending interrupt set.
module riscv_irq_prio #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [3:0]         idx_o
);
    // Scan from the top down so the lowest set index is the last one kept
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 4'(i);
            end
        end
    end
endmodule

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap/CSR sequencer beside EX: holds the M-mode trap CSRs,
// arbitrates exceptions, interrupts and MRET, and runs flush -> redirect.
module riscv_trap_ctrl
    import riscv_trap_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              NUM_IRQ      = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int              FLUSH_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    riscv_trap_ctrl_if.slave bus
);
    trap_state_e        state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               mstatus_mie_q, mstatus_mpie_q;
    logic [NUM_IRQ-1:0] mie_q, mip_q;
    logic [XLEN-1:0]    mtvec_q, mepc_q, mcause_q, target_q;

    logic [XLEN-1:0]    mstatus_v, mie_v, mip_v, rdata, wval;
    logic               addr_hit;
    logic               irq_valid;
    logic [3:0]         irq_idx;
    logic               ev, csr_req, illegal_eff;
    logic               take_exc, take_irq, take_trap, take_mret, csr_we;
    logic [XLEN-1:0]    vec_base, irq_code, cause, trap_target;

    riscv_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req_i   (mie_q & mip_q),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    // Expand the compact CSR state into full-width architectural views
    always_comb begin
        mstatus_v                      = '0;
        mstatus_v[MSTATUS_MIE]         = mstatus_mie_q;
        mstatus_v[MSTATUS_MPIE]        = mstatus_mpie_q;
        mie_v                          = '0;
        mie_v[IRQ_BASE +: NUM_IRQ]     = mie_q;
        mip_v                          = '0;
        mip_v[IRQ_BASE +: NUM_IRQ]     = mip_q;
    end

    // CSR read mux: always the pre-update value; flags unmapped addresses
    always_comb begin
        rdata    = '0;
        addr_hit = 1'b1;
        case (bus.csr_addr)
            CSR_MSTATUS: rdata = mstatus_v;
            CSR_MIE:     rdata = mie_v;
            CSR_MTVEC:   rdata = mtvec_q;
            CSR_MEPC:    rdata = mepc_q;
            CSR_MCAUSE:  rdata = mcause_q;
            CSR_MIP:     rdata = mip_v;
            default:     addr_hit = 1'b0;
        endcase
    end
    assign bus.csr_rdata = rdata;

    // Read-modify-write value for csrrw / csrrs / csrrc
    always_comb begin
        case (csr_op_e'(bus.csr_op))
            CSR_WRITE: wval = bus.csr_wdata;
            CSR_SET:   wval = rdata | bus.csr_wdata;
            CSR_CLEAR: wval = rdata & ~bus.csr_wdata;
            default:   wval = rdata;
        endcase
    end

    // Event arbitration: illegal > ecall > interrupt > mret, only in IDLE with a valid EX
    assign ev          = (state_q == ST_IDLE) && bus.ex_valid;
    assign csr_req     = (bus.csr_op != CSR_NONE);
    assign illegal_eff = bus.ex_illegal | (csr_req & ~addr_hit);
    assign take_exc    = ev & (illegal_eff | bus.ex_ecall);
    assign take_irq    = ev & ~illegal_eff & ~bus.ex_ecall & mstatus_mie_q & irq_valid;
    assign take_trap   = take_exc | take_irq;
    assign take_mret   = ev & bus.ex_mret & ~take_trap;
    assign csr_we      = ev & csr_req & addr_hit & ~take_trap;
    assign vec_base    = mtvec_q & ~XLEN'(3);
    assign irq_code    = XLEN'(IRQ_BASE) + XLEN'(irq_idx);

    // Cause code and trap target; vectored mode offsets only for interrupts
    always_comb begin
        cause       = irq_code;
        trap_target = vec_base;
        if (illegal_eff) begin
            cause = XLEN'(CAUSE_ILLEGAL);
        end else if (bus.ex_ecall) begin
            cause = XLEN'(CAUSE_ECALL_M);
        end else begin
            cause[XLEN-1] = 1'b1;
            if (mtvec_q[0]) trap_target = vec_base + {irq_code[XLEN-3:0], 2'b00};
        end
    end

    // FSM next state and pipeline control outputs
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.flush       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.trap_active = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (take_trap || take_mret) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 2'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                bus.flush = 1'b1;
                bus.stall = 1'b1;
                if (cnt_q == 2'd0) state_d = ST_REDIRECT;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_REDIRECT: begin
                bus.flush       = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = target_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, flush counter and latched redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take_trap)      target_q <= trap_target;
            else if (take_mret) target_q <= mepc_q;
        end
    end

    // CSR file: software writes, trap entry and MRET updates, mip sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET & ~XLEN'(2);
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mip_q <= bus.irq_i;
            if (csr_we) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= wval[MSTATUS_MIE];
                        mstatus_mpie_q <= wval[MSTATUS_MPIE];
                    end
                    CSR_MIE:    mie_q    <= wval[IRQ_BASE +: NUM_IRQ];
                    CSR_MTVEC:  mtvec_q  <= wval & ~XLEN'(2);
                    CSR_MEPC:   mepc_q   <= wval & ~XLEN'(3);
                    CSR_MCAUSE: mcause_q <= wval;
                    default: ;
                endcase
            end
            if (take_trap) begin
                mepc_q         <= bus.ex_pc & ~XLEN'(3);
                mcause_q       <= cause;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Scoreboard bench for riscv_trap_ctrl: stimulus pushes expected probe
// results and redirect targets; a negedge monitor pops and compares.
module tb_riscv_trap_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_trap_ctrl_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

    riscv_trap_ctrl #(
        .XLEN(32), .NUM_IRQ(4), .MTVEC_RESET(32'h0000_0100), .FLUSH_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // sel: 0 = csr_rdata, 1 = {flush,stall,redirect,trap_active}, 2 = redirects still owed
    typedef struct { string name; int sel; logic [31:0] exp; } probe_t;
    typedef struct { string name; logic [31:0] pc; int cyc; } red_t;

    probe_t pq[$];
    red_t   rq[$];
    int     vectors    = 0;
    int     miscompares = 0;
    int     cyc        = 0;
    logic   probe_req  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every probe and every redirect strobe against the queues
    always @(negedge clk) begin
        if (probe_req) begin
            probe_t      p;
            logic [31:0] act;
            vectors++;
            if (pq.size() == 0) begin
                miscompares++;
                $display("FAIL probe_underflow: got empty queue, required an entry");
            end else begin
                p = pq.pop_front();
                case (p.sel)
                    0:       act = bus.csr_rdata;
                    1:       act = {28'd0, bus.flush, bus.stall, bus.redirect, bus.trap_active};
                    default: act = 32'(rq.size());
                endcase
                if (act !== p.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h, required %h", p.name, act, p.exp);
                end else begin
                    $display("ok   %s: %h", p.name, act);
                end
            end
        end
        if (bus.redirect === 1'b1) begin
            red_t r;
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_redirect: got redirect_pc %h at cycle %0d, required no redirect",
                         bus.redirect_pc, cyc);
            end else begin
                r = rq.pop_front();
                if (bus.redirect_pc !== r.pc || cyc != r.cyc) begin
                    miscompares++;
                    $display("FAIL %s: got redirect_pc %h at cycle %0d, required %h at cycle %0d",
                             r.name, bus.redirect_pc, cyc, r.pc, r.cyc);
                end else begin
                    $display("ok   %s: redirect_pc %h at cycle %0d", r.name, bus.redirect_pc, cyc);
                end
            end
        end
    end

    task automatic idle_bus();
        bus.ex_valid   = 1'b0;
        bus.ex_pc      = '0;
        bus.ex_illegal = 1'b0;
        bus.ex_ecall   = 1'b0;
        bus.ex_mret    = 1'b0;
        bus.csr_op     = 2'b00;
        bus.csr_addr   = '0;
        bus.csr_wdata  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.ex_valid  = 1'b1;
        bus.ex_pc     = 32'h0000_0F00;
        bus.csr_op    = op;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        step();
        idle_bus();
    endtask

    task automatic probe(input string n, input int sel, input logic [31:0] e, input logic [11:0] a);
        probe_t p;
        p.name = n; p.sel = sel; p.exp = e;
        bus.csr_addr = a;
        pq.push_back(p);
        probe_req = 1'b1;
        step();
        probe_req = 1'b0;
    endtask

    // Present one EX instruction; csr_op/addr/wdata set by the caller are kept for this cycle
    task automatic issue(input logic [31:0] pc, input logic ill, input logic ecall, input logic mret,
                         input string n, input logic exp_red, input logic [31:0] tgt);
        red_t r;
        if (exp_red) begin
            r.name = n; r.pc = tgt; r.cyc = cyc + 3;
            rq.push_back(r);
        end
        bus.ex_valid   = 1'b1;
        bus.ex_pc      = pc;
        bus.ex_illegal = ill;
        bus.ex_ecall   = ecall;
        bus.ex_mret    = mret;
        step();
        idle_bus();
    endtask

    task automatic wait_idle(input string n);
        for (int i = 0; i < 20 && bus.trap_active === 1'b1; i++) step();
        probe({n, "_back_idle"}, 1, 32'h0, 12'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        bus.irq_i = 4'b0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        probe("rst_flags",   1, 32'h0,         12'h000);
        probe("rst_mstatus", 0, 32'h0,         12'h300);
        probe("rst_mtvec",   0, 32'h0000_0100, 12'h305);

        // Illegal instruction with direct mtvec
        csr(2'b01, 12'h305, 32'h0000_0200);
        probe("mtvec_write", 0, 32'h0000_0200, 12'h305);
        csr(2'b10, 12'h300, 32'h0000_0008);
        probe("mstatus_mie_set", 0, 32'h0000_0008, 12'h300);
        issue(32'h40, 1'b1, 1'b0, 1'b0, "illegal_redirect", 1'b1, 32'h0000_0200);
        probe("illegal_flags_c1", 1, 32'hD, 12'h000);
        wait_idle("illegal");
        probe("illegal_mepc",    0, 32'h0000_0040, 12'h341);
        probe("illegal_mcause",  0, 32'h0000_0002, 12'h342);
        probe("illegal_mstatus", 0, 32'h0000_0080, 12'h300);

        // ECALL then MRET round trip
        csr(2'b10, 12'h300, 32'h0000_0008);
        issue(32'h80, 1'b0, 1'b1, 1'b0, "ecall_redirect", 1'b1, 32'h0000_0200);
        wait_idle("ecall");
        probe("ecall_mcause",  0, 32'h0000_000B, 12'h342);
        probe("ecall_mepc",    0, 32'h0000_0080, 12'h341);
        probe("ecall_mstatus", 0, 32'h0000_0080, 12'h300);
        issue(32'h200, 1'b0, 1'b0, 1'b1, "mret_redirect", 1'b1, 32'h0000_0080);
        wait_idle("mret");
        probe("mret_mstatus", 0, 32'h0000_0088, 12'h300);

        // Vectored interrupts, lowest index first
        csr(2'b01, 12'h305, 32'h0000_0303);
        probe("mtvec_bit1_forced", 0, 32'h0000_0301, 12'h305);
        csr(2'b01, 12'h304, 32'h0003_0000);
        bus.irq_i = 4'b0011;
        step();
        issue(32'h1000, 1'b0, 1'b0, 1'b0, "irq0_vectored", 1'b1, 32'h0000_0340);
        wait_idle("irq0");
        probe("irq0_mcause",  0, 32'h8000_0010, 12'h342);
        probe("irq0_mepc",    0, 32'h0000_1000, 12'h341);
        probe("irq0_mstatus", 0, 32'h0000_0080, 12'h300);
        csr(2'b11, 12'h304, 32'h0001_0000);
        csr(2'b10, 12'h300, 32'h0000_0008);
        issue(32'h2000, 1'b0, 1'b0, 1'b0, "irq1_vectored", 1'b1, 32'h0000_0344);
        wait_idle("irq1");
        probe("irq1_mcause", 0, 32'h8000_0011, 12'h342);
        probe("irq1_mie",    0, 32'h0002_0000, 12'h304);
        bus.irq_i = 4'b0000;

        // Interrupt masked by MIE=0, then enabled
        csr(2'b01, 12'h304, 32'h0001_0000);
        bus.irq_i = 4'b0001;
        step();
        issue(32'h3000, 1'b0, 1'b0, 1'b0, "masked_irq", 1'b0, 32'h0);
        probe("masked_no_trap", 1, 32'h0,         12'h000);
        probe("masked_mip",     0, 32'h0001_0000, 12'h344);
        csr(2'b10, 12'h300, 32'h0000_0008);
        issue(32'h3004, 1'b0, 1'b0, 1'b0, "unmasked_irq", 1'b1, 32'h0000_0340);
        wait_idle("unmasked");
        probe("unmasked_mcause", 0, 32'h8000_0010, 12'h342);
        probe("unmasked_mepc",   0, 32'h0000_3004, 12'h341);
        bus.irq_i = 4'b0000;

        // CSR write colliding with an illegal trap; unmapped CSR is illegal
        bus.csr_op = 2'b01; bus.csr_addr = 12'h304; bus.csr_wdata = 32'h0;
        issue(32'h500, 1'b1, 1'b0, 1'b0, "collide_redirect", 1'b1, 32'h0000_0300);
        wait_idle("collide");
        probe("collide_mie_kept", 0, 32'h0001_0000, 12'h304);
        probe("collide_mcause",   0, 32'h0000_0002, 12'h342);
        probe("collide_mstatus",  0, 32'h0000_0000, 12'h300);
        csr(2'b01, 12'h342, 32'h0);
        probe("mcause_cleared", 0, 32'h0, 12'h342);
        bus.csr_op = 2'b01; bus.csr_addr = 12'h7C0; bus.csr_wdata = 32'h1234;
        issue(32'h600, 1'b0, 1'b0, 1'b0, "unmapped_redirect", 1'b1, 32'h0000_0300);
        wait_idle("unmapped");
        probe("unmapped_mcause", 0, 32'h0000_0002, 12'h342);
        probe("unmapped_mepc",   0, 32'h0000_0600, 12'h341);

        // MRET with an interrupt pending: the interrupt wins
        csr(2'b10, 12'h300, 32'h0000_0008);
        bus.irq_i = 4'b0001;
        step();
        issue(32'h700, 1'b0, 1'b0, 1'b1, "mret_vs_irq", 1'b1, 32'h0000_0340);
        wait_idle("mret_vs_irq");
        probe("mret_irq_mcause",  0, 32'h8000_0010, 12'h342);
        probe("mret_irq_mepc",    0, 32'h0000_0700, 12'h341);
        probe("mret_irq_mstatus", 0, 32'h0000_0080, 12'h300);
        bus.irq_i = 4'b0000;

        // Reset during the second FLUSH cycle
        issue(32'h900, 1'b0, 1'b1, 1'b0, "reset_abort", 1'b0, 32'h0);
        probe("abort_flush_c1", 1, 32'hD, 12'h000);
        rst = 1'b1;
        probe("abort_flags_in_rst", 1, 32'h0, 12'h000);
        rst = 1'b0;
        repeat (4) step();
        probe("post_rst_mtvec",   0, 32'h0000_0100, 12'h305);
        probe("post_rst_mstatus", 0, 32'h0,         12'h300);
        probe("post_rst_mie",     0, 32'h0,         12'h304);
        probe("post_rst_mepc",    0, 32'h0,         12'h341);
        probe("post_rst_mcause",  0, 32'h0,         12'h342);
        probe("post_rst_mip",     0, 32'h0,         12'h344);
        probe("post_rst_flags",   1, 32'h0,         12'h000);
        probe("redirects_owed",   2, 32'h0,         12'h000);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
